// File: rtl/fpga_data_source_if.sv
// Avalon-MM register port plus 8-bit AXI4-Stream output of fpga_data_source.
// "slave" is the data source itself; "master" is the HPS/sink side facing it.
interface fpga_data_source_if;
    logic [1:0]  avs_address;
    logic        avs_chipselect;
    logic        avs_write_n;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic [7:0]  axis4_m_tdata;
    logic        axis4_m_tvalid;
    logic        axis4_m_tlast;
    logic        axis4_m_tready;

    modport slave (
        input  avs_address, avs_chipselect, avs_write_n, avs_writedata, axis4_m_tready,
        output avs_readdata, axis4_m_tdata, axis4_m_tvalid, axis4_m_tlast
    );

    modport master (
        output avs_address, avs_chipselect, avs_write_n, avs_writedata, axis4_m_tready,
        input  avs_readdata, axis4_m_tdata, axis4_m_tvalid, axis4_m_tlast
    );
endinterface

// File: rtl/fpga_data_source.sv
// Avalon-loaded 32x8 byte RAM that streams bursts (RAM bytes or an incrementing
// pattern) out of an 8-bit AXI4-Stream master, one beat every two cycles.
module fpga_data_source #(
    parameter int DEPTH_LOG2 = 5,
    parameter int MAX_LEN    = 32
) (
    input  logic              clk,
    input  logic              reset,
    fpga_data_source_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, FETCH, SEND} state_e;

    localparam logic [5:0] MaxLenW = 6'(MAX_LEN);

    state_e                  state_q, state_d;
    logic                    go_q, go_d;
    logic [1:0]              cmd_q, cmd_d;
    logic [DEPTH_LOG2-1:0]   addr_q, addr_d;
    logic [7:0]              wdata_q, wdata_d;
    logic                    busy_q, busy_d;
    logic [7:0]              rdByte_q, rdByte_d;
    logic [5:0]              beats_q, beats_d;
    logic [5:0]              len_q, len_d;
    logic                    patEn_q, patEn_d;
    logic [7:0]              seed_q, seed_d;
    logic [DEPTH_LOG2-1:0]   ptr_q, ptr_d;
    logic [5:0]              burstLen_q, burstLen_d;
    logic                    burstPat_q, burstPat_d;
    logic [7:0]              burstSeed_q, burstSeed_d;
    logic [7:0]              tdata_q, tdata_d;
    logic                    tvalid_q, tvalid_d;
    logic                    tlast_q, tlast_d;

    logic [7:0]              mem [0:(2**DEPTH_LOG2)-1];
    logic [7:0]              ramRd_q;
    logic                    memWe;
    logic                    avWrite;
    logic [5:0]              effLen;
    logic                    unusedWdata;

    assign avWrite     = bus.avs_chipselect & ~bus.avs_write_n;
    assign effLen      = (len_q == 6'd0 || len_q > MaxLenW) ? MaxLenW : len_q;
    assign unusedWdata = ^{bus.avs_writedata[31:24], bus.avs_writedata[7:6]};

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (go_q && cmd_q == 2'b00) state_d = RD_WAIT;
                if (go_q && cmd_q == 2'b10) state_d = FETCH;
            end
            RD_WAIT: state_d = IDLE;
            FETCH:   state_d = SEND;
            SEND: begin
                if (bus.axis4_m_tready) state_d = tlast_q ? IDLE : FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    // Command decode, burst datapath and register writes; a CTRL write from
    // Avalon overrides the hardware go-clear, but only while not busy.
    always_comb begin
        go_d        = go_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        busy_d      = busy_q;
        rdByte_d    = rdByte_q;
        beats_d     = beats_q;
        len_d       = len_q;
        patEn_d     = patEn_q;
        seed_d      = seed_q;
        ptr_d       = ptr_q;
        burstLen_d  = burstLen_q;
        burstPat_d  = burstPat_q;
        burstSeed_d = burstSeed_q;
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        memWe       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (go_q) begin
                    go_d = 1'b0;
                    unique case (cmd_q)
                        2'b00: busy_d = 1'b1;
                        2'b01: memWe = 1'b1;
                        2'b10: begin
                            ptr_d       = addr_q;
                            burstLen_d  = effLen;
                            burstPat_d  = patEn_q;
                            burstSeed_d = seed_q;
                            beats_d     = 6'd0;
                            busy_d      = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            RD_WAIT: begin
                rdByte_d = ramRd_q;
                busy_d   = 1'b0;
            end
            FETCH: begin
                tdata_d  = burstPat_q ? burstSeed_q + {2'b00, beats_q} : mem[ptr_q];
                tvalid_d = 1'b1;
                tlast_d  = (beats_q == burstLen_q - 6'd1);
            end
            SEND: begin
                if (bus.axis4_m_tready) begin
                    beats_d  = beats_q + 6'd1;
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    if (tlast_q) busy_d = 1'b0;
                    else         ptr_d  = ptr_q + 1'b1;
                end
            end
            default: ;
        endcase

        if (avWrite && bus.avs_address == 2'd0 && !busy_q) begin
            go_d    = bus.avs_writedata[0];
            cmd_d   = bus.avs_writedata[2:1];
            addr_d  = bus.avs_writedata[8 +: DEPTH_LOG2];
            wdata_d = bus.avs_writedata[23:16];
        end
        if (avWrite && bus.avs_address == 2'd2) len_d = bus.avs_writedata[5:0];
        if (avWrite && bus.avs_address == 2'd3) begin
            patEn_d = bus.avs_writedata[0];
            seed_d  = bus.avs_writedata[15:8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            go_q        <= 1'b0;
            cmd_q       <= 2'b00;
            addr_q      <= '0;
            wdata_q     <= 8'd0;
            busy_q      <= 1'b0;
            rdByte_q    <= 8'd0;
            beats_q     <= 6'd0;
            len_q       <= 6'd0;
            patEn_q     <= 1'b0;
            seed_q      <= 8'd0;
            ptr_q       <= '0;
            burstLen_q  <= 6'd0;
            burstPat_q  <= 1'b0;
            burstSeed_q <= 8'd0;
            tdata_q     <= 8'd0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
        end else begin
            go_q        <= go_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            busy_q      <= busy_d;
            rdByte_q    <= rdByte_d;
            beats_q     <= beats_d;
            len_q       <= len_d;
            patEn_q     <= patEn_d;
            seed_q      <= seed_d;
            ptr_q       <= ptr_d;
            burstLen_q  <= burstLen_d;
            burstPat_q  <= burstPat_d;
            burstSeed_q <= burstSeed_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
        end
    end

    // RAM contents survive reset; the registered read feeds RD_WAIT.
    always_ff @(posedge clk) begin
        if (memWe) mem[addr_q] <= wdata_q;
        ramRd_q <= mem[addr_q];
    end

    always_comb begin
        bus.avs_readdata = 32'd0;
        unique case (bus.avs_address)
            2'd0: begin
                bus.avs_readdata[0]                = go_q;
                bus.avs_readdata[2:1]              = cmd_q;
                bus.avs_readdata[8 +: DEPTH_LOG2]  = addr_q;
                bus.avs_readdata[23:16]            = wdata_q;
            end
            2'd1: begin
                bus.avs_readdata[0]     = busy_q;
                bus.avs_readdata[15:8]  = rdByte_q;
                bus.avs_readdata[21:16] = beats_q;
            end
            2'd2: bus.avs_readdata[5:0] = len_q;
            default: begin
                bus.avs_readdata[0]    = patEn_q;
                bus.avs_readdata[15:8] = seed_q;
            end
        endcase
    end

    assign bus.axis4_m_tdata  = tdata_q;
    assign bus.axis4_m_tvalid = tvalid_q;
    assign bus.axis4_m_tlast  = tlast_q;
endmodule

// File: tb/tb_fpga_data_source.sv
// Directed self-checking bench for fpga_data_source: register access, RAM
// read/write, bursts with wrap, pattern, backpressure, clamp and mid-burst reset.
module tb_fpga_data_source;
    logic clk = 1'b0;
    logic reset;

    fpga_data_source_if bus();

    fpga_data_source #(.DEPTH_LOG2(5), .MAX_LEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  gotData [64];
    bit          gotLast [64];
    int          gotCount;
    int          stallErrs;
    bit          timedOut;
    logic [31:0] rd;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Inputs change 1 ns after the rising edge, outputs are sampled there too.
    task automatic avWrite(input logic [1:0] a, input logic [31:0] d);
        bus.avs_address    = a;
        bus.avs_writedata  = d;
        bus.avs_chipselect = 1'b1;
        bus.avs_write_n    = 1'b0;
        @(posedge clk); #1;
        bus.avs_chipselect = 1'b0;
        bus.avs_write_n    = 1'b1;
    endtask

    task automatic readReg(input logic [1:0] a, output logic [31:0] d);
        bus.avs_address = a;
        #1;
        d = bus.avs_readdata;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic collectBurst(input bit randomReady);
        bit         rdy;
        bit         prevStall;
        bit         lastHs;
        logic [7:0] prevData;
        logic       prevLast;
        gotCount  = 0;
        stallErrs = 0;
        timedOut  = 1'b1;
        prevStall = 1'b0;
        prevData  = 8'd0;
        prevLast  = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (prevStall && (bus.axis4_m_tvalid !== 1'b1 || bus.axis4_m_tdata !== prevData ||
                              bus.axis4_m_tlast !== prevLast))
                stallErrs++;
            rdy = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.axis4_m_tready = rdy;
            lastHs = 1'b0;
            if (bus.axis4_m_tvalid === 1'b1 && rdy) begin
                if (gotCount < 64) begin
                    gotData[gotCount] = bus.axis4_m_tdata;
                    gotLast[gotCount] = (bus.axis4_m_tlast === 1'b1);
                end
                gotCount++;
                lastHs = (bus.axis4_m_tlast === 1'b1);
            end
            prevStall = (bus.axis4_m_tvalid === 1'b1) && !rdy;
            prevData  = bus.axis4_m_tdata;
            prevLast  = bus.axis4_m_tlast;
            @(posedge clk); #1;
            if (lastHs) begin
                timedOut = 1'b0;
                break;
            end
        end
        bus.axis4_m_tready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idleCycles(2);
        for (int a = 0; a < 4; a++) begin
            readReg(2'(a), rd);
            vectors++;
            if (rd !== 32'd0) begin
                miscompares++;
                $display("[TB] FAIL reset_reg%0d: got %h expected 00000000", a, rd);
            end
        end
        vectors++;
        if (bus.axis4_m_tvalid !== 1'b0 || bus.axis4_m_tlast !== 1'b0 || bus.axis4_m_tdata !== 8'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_axis: got v=%b l=%b d=%h expected v=0 l=0 d=00",
                     bus.axis4_m_tvalid, bus.axis4_m_tlast, bus.axis4_m_tdata);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        avWrite(2'd0, 32'h00A7_0503);
        idleCycles(1);
        readReg(2'd0, rd);
        vectors++;
        if (rd !== 32'h00A7_0502) begin
            miscompares++;
            $display("[TB] FAIL ctrl_go_clear: got %h expected 00a70502", rd);
        end
        readReg(2'd1, rd);
        vectors++;
        if (rd[0] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL write_busy: got %b expected 0", rd[0]);
        end
        avWrite(2'd0, 32'h0000_0501);
        idleCycles(1);
        readReg(2'd1, rd);
        vectors++;
        if (rd[0] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL read_busy_set: got %b expected 1", rd[0]);
        end
        idleCycles(1);
        readReg(2'd1, rd);
        vectors++;
        if (rd[0] !== 1'b0 || rd[15:8] !== 8'hA7) begin
            miscompares++;
            $display("[TB] FAIL read_byte: got busy=%b byte=%h expected busy=0 byte=a7", rd[0], rd[15:8]);
        end
    endtask

    task automatic test_stream_basic();
        for (int i = 0; i < 32; i++) begin
            avWrite(2'd0, {8'd0, 8'(i), 3'd0, 5'(i), 8'h03});
            idleCycles(1);
        end
        avWrite(2'd2, 32'd4);
        avWrite(2'd0, 32'h0000_0305);
        collectBurst(1'b0);
        vectors++;
        if (timedOut || gotCount != 4) begin
            miscompares++;
            $display("[TB] FAIL basic_count: got %0d beats (timeout=%0b) expected 4", gotCount, timedOut);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (gotData[i] !== 8'(3 + i) || gotLast[i] != (i == 3)) begin
                miscompares++;
                $display("[TB] FAIL basic_beat%0d: got %h last=%0b expected %h last=%0b",
                         i, gotData[i], gotLast[i], 8'(3 + i), (i == 3));
            end
        end
        readReg(2'd1, rd);
        vectors++;
        if (rd[21:16] !== 6'd4 || rd[0] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL basic_stat: got beats=%0d busy=%b expected beats=4 busy=0", rd[21:16], rd[0]);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] expBeat [4];
        expBeat = '{8'h1E, 8'h1F, 8'h00, 8'h01};
        avWrite(2'd0, 32'h0000_1E05);
        collectBurst(1'b0);
        vectors++;
        if (timedOut || gotCount != 4) begin
            miscompares++;
            $display("[TB] FAIL wrap_count: got %0d beats (timeout=%0b) expected 4", gotCount, timedOut);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (gotData[i] !== expBeat[i] || gotLast[i] != (i == 3)) begin
                miscompares++;
                $display("[TB] FAIL wrap_beat%0d: got %h last=%0b expected %h last=%0b",
                         i, gotData[i], gotLast[i], expBeat[i], (i == 3));
            end
        end
    endtask

    task automatic test_pattern();
        logic [7:0] expBeat [3];
        expBeat = '{8'hFE, 8'hFF, 8'h00};
        avWrite(2'd3, 32'h0000_FE01);
        avWrite(2'd2, 32'd3);
        avWrite(2'd0, 32'h0000_0005);
        collectBurst(1'b0);
        vectors++;
        if (timedOut || gotCount != 3) begin
            miscompares++;
            $display("[TB] FAIL pat_count: got %0d beats (timeout=%0b) expected 3", gotCount, timedOut);
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (gotData[i] !== expBeat[i] || gotLast[i] != (i == 2)) begin
                miscompares++;
                $display("[TB] FAIL pat_beat%0d: got %h last=%0b expected %h last=%0b",
                         i, gotData[i], gotLast[i], expBeat[i], (i == 2));
            end
        end
        avWrite(2'd3, 32'h0000_0000);
    endtask

    task automatic test_back_to_back();
        int lastCount;
        avWrite(2'd2, 32'd0);
        avWrite(2'd0, 32'h0000_0705);
        collectBurst(1'b1);
        vectors++;
        if (timedOut || gotCount != 32) begin
            miscompares++;
            $display("[TB] FAIL bp_count: got %0d beats (timeout=%0b) expected 32", gotCount, timedOut);
        end
        vectors++;
        if (stallErrs != 0) begin
            miscompares++;
            $display("[TB] FAIL bp_stable: got %0d unstable stall cycles expected 0", stallErrs);
        end
        lastCount = 0;
        for (int i = 0; i < 32; i++) begin
            if (gotLast[i]) lastCount++;
            vectors++;
            if (gotData[i] !== 8'((7 + i) % 32)) begin
                miscompares++;
                $display("[TB] FAIL bp_beat%0d: got %h expected %h", i, gotData[i], 8'((7 + i) % 32));
            end
        end
        vectors++;
        if (lastCount != 1 || !gotLast[31]) begin
            miscompares++;
            $display("[TB] FAIL bp_tlast: got %0d tlast (final=%0b) expected 1 on beat 31", lastCount, gotLast[31]);
        end
        readReg(2'd1, rd);
        vectors++;
        if (rd[21:16] !== 6'd32) begin
            miscompares++;
            $display("[TB] FAIL bp_stat: got beats=%0d expected 32", rd[21:16]);
        end
    endtask

    task automatic test_len_clamp();
        avWrite(2'd2, 32'd40);
        avWrite(2'd0, 32'h0000_0005);
        collectBurst(1'b0);
        vectors++;
        if (timedOut || gotCount != 32 || !gotLast[31] || gotData[31] !== 8'h1F) begin
            miscompares++;
            $display("[TB] FAIL clamp: got %0d beats final=%h last=%0b expected 32 beats final=1f last=1",
                     gotCount, gotData[31], gotLast[31]);
        end
    endtask

    task automatic test_reset_mid_burst();
        int hs = 0;
        bit hsNext;
        avWrite(2'd2, 32'd8);
        avWrite(2'd0, 32'h0000_0005);
        for (int cyc = 0; cyc < 40 && hs < 2; cyc++) begin
            hsNext = (bus.axis4_m_tvalid === 1'b1);
            @(posedge clk); #1;
            if (hsNext) hs++;
        end
        vectors++;
        if (hs != 2) begin
            miscompares++;
            $display("[TB] FAIL mid_wait: got %0d handshakes expected 2", hs);
        end
        bus.axis4_m_tready = 1'b0;
        avWrite(2'd0, 32'h0000_1003);
        vectors++;
        if (bus.axis4_m_tvalid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL mid_stall_valid: got %b expected 1", bus.axis4_m_tvalid);
        end
        readReg(2'd0, rd);
        vectors++;
        if (rd !== 32'h0000_0004) begin
            miscompares++;
            $display("[TB] FAIL busy_ctrl_ignored: got %h expected 00000004", rd);
        end
        readReg(2'd1, rd);
        vectors++;
        if (rd[0] !== 1'b1 || rd[21:16] !== 6'd2) begin
            miscompares++;
            $display("[TB] FAIL mid_stat: got busy=%b beats=%0d expected busy=1 beats=2", rd[0], rd[21:16]);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (bus.axis4_m_tvalid !== 1'b0 || bus.axis4_m_tlast !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL mid_reset_axis: got v=%b l=%b expected v=0 l=0", bus.axis4_m_tvalid, bus.axis4_m_tlast);
        end
        readReg(2'd1, rd);
        vectors++;
        if (rd !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL mid_reset_stat: got %h expected 00000000", rd);
        end
        reset = 1'b0;
        bus.axis4_m_tready = 1'b1;
        @(posedge clk); #1;
        avWrite(2'd0, 32'h0000_1001);
        idleCycles(2);
        readReg(2'd1, rd);
        vectors++;
        if (rd[15:8] !== 8'h10) begin
            miscompares++;
            $display("[TB] FAIL ram16_kept: got %h expected 10", rd[15:8]);
        end
        avWrite(2'd2, 32'd2);
        avWrite(2'd0, 32'h0000_0905);
        collectBurst(1'b0);
        vectors++;
        if (timedOut || gotCount != 2 || gotData[0] !== 8'h09 || gotData[1] !== 8'h0A ||
            gotLast[0] || !gotLast[1]) begin
            miscompares++;
            $display("[TB] FAIL post_reset_burst: got n=%0d %h %h last=%0b%0b expected n=2 09 0a last=01",
                     gotCount, gotData[0], gotData[1], gotLast[0], gotLast[1]);
        end
    endtask

    initial begin
        reset              = 1'b1;
        bus.avs_address    = 2'd0;
        bus.avs_chipselect = 1'b0;
        bus.avs_write_n    = 1'b1;
        bus.avs_writedata  = 32'd0;
        bus.axis4_m_tready = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_write_read();
        test_stream_basic();
        test_wrap();
        test_pattern();
        test_back_to_back();
        test_len_clamp();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
